muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter Width, default 32, operand/result width in bits (legal: even, >= 8).
REQ-002 SHALL have parameter CntW, default $clog2(Width)+1, division iteration counter width; not overridden by instantiators.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port kill  input  1  abort in-flight operation.
REQ-007 SHALL have port op  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports a, b  input  Width  operands; rs1 and rs2 respectively.
REQ-009 SHALL have port ready  output  1  high when idle and able to accept.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port c  output  Width  result; held until the next accepted start.

Function
REQ-012 SHALL have states IDLE, MUL, DIV, FIX; ready=1 only in IDLE.
REQ-013 SHALL accept on any edge with start=1, ready=1, kill=0; a, b, op registered at that edge, later input changes ignored.
REQ-014 SHALL ignore start when ready=0; no queueing.
REQ-015 Multiply ops: IDLE->MUL on accept; done=1 and c valid in the following cycle (latency 1); MUL->IDLE.
REQ-016 MUL/MULH/MULHSU/MULHU SHALL return low product, signed*signed high, signed*unsigned high, unsigned*unsigned high of the 2*Width product respectively.
REQ-017 Divide ops: IDLE->DIV on accept; restoring radix-2 on operand magnitudes, one quotient bit per cycle, exactly Width cycles in DIV; DIV->FIX.
REQ-018 FIX SHALL apply sign: quotient negated when signed and sign(a)!=sign(b); remainder takes sign of a; done=1 with c valid in FIX; FIX->IDLE.
REQ-019 Normal divide latency SHALL be Width+1 cycles from accept edge to done cycle (Width DIV + 1 FIX).
REQ-020 Divide by zero SHALL give quotient all-ones (DIV, DIVU) and remainder = a (REM, REMU).
REQ-021 Signed overflow (a = most-negative, b = -1) SHALL give DIV = a, REM = 0.
REQ-022 kill=1 in MUL, DIV or FIX SHALL return to IDLE at that edge with no done pulse; c unchanged.
REQ-023 kill=1 with start=1 in IDLE SHALL not accept.
REQ-024 ready SHALL return to 1 in the cycle after the done pulse; back-to-back start accepted then.
REQ-025 done SHALL never be high for two consecutive cycles.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, ready=1, done=0, c=0, counter=0, overriding start and kill.
REQ-027 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-028 Macro MULDIV_SEQ_EARLY_OUT_EN: when defined, divide by zero and signed overflow SHALL bypass DIV, going IDLE->FIX with done one cycle after accept; when undefined, these cases take full Width+1 latency with identical results.

Verification (Width=32)
REQ-029 Reset, then start op=000 a=7 b=-3 -> done next cycle, c=0xFFFFFFEB; ready back to 1 the following cycle.
REQ-030 op=001 a=0x80000000 b=0x80000000 -> c=0x40000000; op=011 a=b=0xFFFFFFFF -> c=0xFFFFFFFE; op=010 a=-1 b=0xFFFFFFFF -> c=0xFFFFFFFF.
REQ-031 op=100 a=-7 b=2 -> done 33 cycles after accept, c=0xFFFFFFFD; op=110 same operands -> c=0xFFFFFFFF.
REQ-032 op=101 a=5 b=0 -> c=0xFFFFFFFF; op=100 a=0x80000000 b=-1 -> c=0x80000000; latency 1 with MULDIV_SEQ_EARLY_OUT_EN, 33 without.
REQ-033 op=101 accepted, kill at cycle 10 -> no done, ready=1 next cycle, c retains previous value; start during busy ignored.
REQ-034 rst_n=0 at cycle 5 of a divide -> c=0, done never pulses, ready=1.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// Define MULDIV_SEQ_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the iteration phase.
//
// state | meaning
// IDLE  | ready, waiting for an accepted start
// MUL   | product available, done pulse
// DIV   | one quotient bit per cycle on operand magnitudes
// FIX   | sign correction / special cases, done pulse
module muldiv_seq #(
    parameter int Width = 32,
    parameter int CntW  = $clog2(Width) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [Width-1:0] c
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [Width-1:0] a_q, b_q, c_q, quo, rem, dvs;
    logic [CntW-1:0]  cnt;

    logic             accept, in_signed, early;
    logic [Width-1:0] abs_a, abs_b;

    assign ready     = (state == IDLE);
    assign accept    = start & ready & ~kill;
    assign in_signed = ~op[0];
    assign abs_a     = (in_signed && a[Width-1]) ? -a : a;
    assign abs_b     = (in_signed && b[Width-1]) ? -b : b;

`ifdef MULDIV_SEQ_EARLY_OUT_EN
    assign early = (b == '0) || (in_signed && (a == MinNeg) && (b == '1));
`else
    assign early = 1'b0;
`endif

    // Multiply: extend to 2*Width so one unsigned multiplier covers every signedness mix
    logic                 mul_sa, mul_sb;
    logic [2*Width-1:0]   a_ext, b_ext, prod;
    logic [Width-1:0]     mul_res;

    assign mul_sa  = (op_q == 2'b01) || (op_q == 2'b10);
    assign mul_sb  = (op_q == 2'b01);
    assign a_ext   = {{Width{mul_sa & a_q[Width-1]}}, a_q};
    assign b_ext   = {{Width{mul_sb & b_q[Width-1]}}, b_q};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op_q == 2'b00) ? prod[Width-1:0] : prod[2*Width-1:Width];

    // Restoring divide step: borrow out of the trial subtraction rejects the quotient bit
    logic [Width:0] rem_sh, diff;

    assign rem_sh = {rem, quo[Width-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    logic             div_signed, div_zero, div_ovf, neg_q, neg_r;
    logic [Width-1:0] div_q, div_r, div_res, res;

    assign div_signed = ~op_q[0];
    assign div_zero   = (b_q == '0);
    assign div_ovf    = div_signed && (a_q == MinNeg) && (b_q == '1);
    assign neg_q      = div_signed & (a_q[Width-1] ^ b_q[Width-1]);
    assign neg_r      = div_signed & a_q[Width-1];

    always_comb begin
        div_q = neg_q ? -quo : quo;
        div_r = neg_r ? -rem : rem;
        if (div_zero) begin
            div_q = '1;
            div_r = a_q;
        end else if (div_ovf) begin
            div_q = a_q;
            div_r = '0;
        end
    end

    assign div_res = op_q[1] ? div_r : div_q;
    assign res     = (state == MUL) ? mul_res : div_res;
    assign c       = done ? res : c_q;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = op[2] ? (early ? FIX : DIV) : MUL;
            MUL: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            DIV: if (cnt == '0) state_nxt = FIX;
            FIX: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (kill && (state != IDLE)) begin
            state_nxt = IDLE;
            done      = 1'b0;
        end
        if (!rst_n) done = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (done) c_q <= res;
            if (accept) begin
                op_q <= op[1:0];
                a_q  <= a;
                b_q  <= b;
                quo  <= abs_a;
                rem  <= '0;
                dvs  <= abs_b;
                cnt  <= CntW'(Width - 1);
            end else if (state == DIV) begin
                if (!diff[Width]) begin
                    rem <= diff[Width-1:0];
                    quo <= {quo[Width-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[Width-1:0];
                    quo <= {quo[Width-2:0], 1'b0};
                end
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (Width=32): directed vector table, kill/reset sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, done;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_SEQ_EARLY_OUT_EN
    localparam int SpecLat = 1;
`else
    localparam int SpecLat = 33;
`endif

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .kill  (kill),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    logic done_prev = 1'b0;
    logic dbl_done = 1'b0;
    always @(negedge clk) begin
        if (done && done_prev) dbl_done = 1'b1;
        done_prev = done;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [31:0] r, int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.c = r; v.lat = l;
        return v;
    endfunction

    // Reference: plain 64-bit arithmetic with RISC-V division rules
    function automatic logic [31:0] ref_calc(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    function automatic int ref_lat(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        if (!o[2]) return 1;
        if (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return SpecLat;
        return 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called and returns at posedge+1; leaves the bench in the cycle after done
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        int guard = 0;
        while (!ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) chk("ready_timeout", {31'b0, ready}, 32'd1);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = c;
        @(posedge clk); #1;
        chk("done_pulse_ready", {30'b0, done, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] prev_c;
        logic        any_done;
        int          lat;

        vecs.push_back(mk(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1));
        vecs.push_back(mk(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1));
        vecs.push_back(mk(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1));
        vecs.push_back(mk(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1));
        vecs.push_back(mk(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
        vecs.push_back(mk(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
        vecs.push_back(mk(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, SpecLat));
        vecs.push_back(mk(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SpecLat));
        vecs.push_back(mk(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SpecLat));
        vecs.push_back(mk(3'd7, 32'd5,        32'd0,        32'd5,        SpecLat));
        vecs.push_back(mk(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SpecLat));
        vecs.push_back(mk(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SpecLat));
        vecs.push_back(mk(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33));
        vecs.push_back(mk(3'd7, 32'd100,      32'd7,        32'd2,        33));
        vecs.push_back(mk(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33));

        // Reset state, with start and kill asserted to show reset wins
        rst_n = 1'b0; start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_c",     c,              32'd0);
        start = 1'b0; kill = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_c", i), res, vecs[i].c);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Kill during a divide, with an ignored start while busy
        run_op(3'd0, 32'd6, 32'd7, res, lat);
        prev_c = res;
        chk("pre_kill_c", res, 32'd42);
        op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        any_done = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; end
            if (i == 4) start = 1'b0;
            any_done |= done;
            @(posedge clk); #1;
        end
        kill = 1'b1; #1;
        any_done |= done;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_div_ready", {31'b0, ready}, 32'd1);
        chk("kill_div_c", c, prev_c);
        repeat (40) begin @(posedge clk); #1; any_done |= done; end
        chk("kill_div_nodone", {31'b0, any_done}, 32'd0);

        // kill with start in IDLE must not accept
        start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("kill_idle", {30'b0, done, ready}, 32'd1);

        // Kill in MUL suppresses the done pulse and keeps c
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b1; #1;
        chk("kill_mul_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_mul_ready", {31'b0, ready}, 32'd1);
        chk("kill_mul_c", c, prev_c);

        // Reset at cycle 5 of a divide
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        any_done = 1'b0;
        repeat (4) begin @(posedge clk); #1; any_done |= done; end
        rst_n = 1'b0; #1;
        any_done |= done;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_c", c, 32'd0);
        chk("rst_mid_ready", {31'b0, ready}, 32'd1);
        repeat (40) begin @(posedge clk); #1; any_done |= done; end
        chk("rst_mid_nodone", {31'b0, any_done}, 32'd0);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'h0;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, res, lat);
            chk($sformatf("rnd%0d_op%0d_c", i, ro), res, ref_calc(ro, ra, rb));
            chk($sformatf("rnd%0d_op%0d_lat", i, ro), 32'(lat), 32'(ref_lat(ro, ra, rb)));
        end

        chk("no_double_done", {31'b0, dbl_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
